// File: rtl/controle_pkg.sv
// +----------------------------------------------------------------------+
// | controle_pkg: shared PC-source codes, fetch states and IR layout.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package controle_pkg;

  localparam logic [1:0] FCP_ULA      = 2'b00;
  localparam logic [1:0] FCP_ALVO_ULA = 2'b01;
  localparam logic [1:0] FCP_JUMP     = 2'b10;
  localparam logic [1:0] FCP_NENHUM   = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    BUSCA     = 2'd1,
    CARREGADO = 2'd2
  } estado_busca_t;

  localparam int CAMPO_W    = 4;
  localparam int ALVO_W     = 8;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 8;
  localparam int RS_MSB     = 7;
  localparam int RS_LSB     = 4;
  localparam int RT_MSB     = 3;
  localparam int RT_LSB     = 0;
  localparam int ALVO_MSB   = 7;
  localparam int ALVO_LSB   = 0;

endpackage

`default_nettype wire

// File: rtl/unidade_busca_if.sv
// +----------------------------------------------------------------------+
// | unidade_busca_if: instruction-memory req/ready fetch channel.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface unidade_busca_if #(
  parameter int LARGURA_INSTR = 16,
  parameter int LARGURA_END   = 8
);
  logic                     mem_req;
  logic [LARGURA_END-1:0]   mem_end;
  logic [LARGURA_INSTR-1:0] mem_dado;
  logic                     mem_pronto;

  modport master (
    output mem_req,
    output mem_end,
    input  mem_dado,
    input  mem_pronto
  );

  modport slave (
    input  mem_req,
    input  mem_end,
    output mem_dado,
    output mem_pronto
  );
endinterface

`default_nettype wire

// File: rtl/registrador_pc.sv
// +----------------------------------------------------------------------+
// | registrador_pc: program counter with write-enable and source mux.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module registrador_pc
  import controle_pkg::*;
#(
  parameter int LARGURA_END = 8,
  parameter int END_INICIAL = 0
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   i_esc_cp,
  input  wire logic                   i_esc_cond_cp,
  input  wire logic                   i_zero,
  input  wire logic [1:0]             i_fonte_cp,
  input  wire logic [LARGURA_END-1:0] i_resultado_ula,
  input  wire logic [LARGURA_END-1:0] i_ula_reg,
  input  wire logic [ALVO_W-1:0]      i_alvo,
  output logic      [LARGURA_END-1:0] o_pc
);

  logic [LARGURA_END-1:0] r_pc;
  logic [LARGURA_END-1:0] w_prox_pc;
  logic                   w_fonte_valida;
  logic                   w_escreve;

  always_comb begin
    w_prox_pc      = r_pc;
    w_fonte_valida = 1'b1;
    case (i_fonte_cp)
      FCP_ULA:      w_prox_pc = i_resultado_ula;
      FCP_ALVO_ULA: w_prox_pc = i_ula_reg;
      FCP_JUMP:     w_prox_pc = LARGURA_END'(i_alvo);
      FCP_NENHUM:   w_fonte_valida = 1'b0;
    endcase
  end

  // Source code 11 suppresses the write even when a write is commanded.
  assign w_escreve = (i_esc_cp | (i_esc_cond_cp & i_zero)) & w_fonte_valida;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= LARGURA_END'(END_INICIAL);
    end else if (w_escreve) begin
      r_pc <= w_prox_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/unidade_busca.sv
// +----------------------------------------------------------------------+
// | unidade_busca: instruction fetch stage - PC, IR and memory fetch FSM.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module unidade_busca
  import controle_pkg::*;
#(
  parameter int LARGURA_INSTR = 16,
  parameter int LARGURA_END   = 8,
  parameter int END_INICIAL   = 0
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     EscIR,
  input  wire logic                     EscCP,
  input  wire logic                     EscCondCP,
  input  wire logic [1:0]               FonteCP,
  input  wire logic                     zero,
  input  wire logic [LARGURA_END-1:0]   resultado_ula,
  unidade_busca_if.master               mem,
  output logic      [LARGURA_END-1:0]   PC,
  output logic      [LARGURA_INSTR-1:0] IR,
  output logic      [CAMPO_W-1:0]       opcode,
  output logic      [CAMPO_W-1:0]       rd,
  output logic      [CAMPO_W-1:0]       rs,
  output logic      [CAMPO_W-1:0]       rt,
  output logic      [ALVO_W-1:0]        alvo,
  output logic                          instr_valida,
  output logic                          busca_ativa
);

  estado_busca_t            r_estado;
  estado_busca_t            w_prox_estado;
  logic                     w_inicia_busca;
  logic                     w_captura;
  logic [LARGURA_INSTR-1:0] r_ir;
  logic [LARGURA_END-1:0]   r_mem_end;
  logic [LARGURA_END-1:0]   r_ula_reg;

  registrador_pc #(
    .LARGURA_END (LARGURA_END),
    .END_INICIAL (END_INICIAL)
  ) u_registrador_pc (
    .clk             (clk),
    .reset           (reset),
    .i_esc_cp        (EscCP),
    .i_esc_cond_cp   (EscCondCP),
    .i_zero          (zero),
    .i_fonte_cp      (FonteCP),
    .i_resultado_ula (resultado_ula),
    .i_ula_reg       (r_ula_reg),
    .i_alvo          (r_ir[ALVO_MSB:ALVO_LSB]),
    .o_pc            (PC)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // A new EscIR is only honoured outside BUSCA; requests are not queued.
  always_comb begin
    w_prox_estado  = r_estado;
    w_inicia_busca = 1'b0;
    w_captura      = 1'b0;
    case (r_estado)
      OCIOSO, CARREGADO: begin
        if (EscIR) begin
          w_prox_estado  = BUSCA;
          w_inicia_busca = 1'b1;
        end
      end
      BUSCA: begin
        if (mem.mem_pronto) begin
          w_prox_estado = CARREGADO;
          w_captura     = 1'b1;
        end
      end
      default: w_prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir      <= '0;
      r_mem_end <= '0;
      r_ula_reg <= '0;
    end else begin
      r_ula_reg <= resultado_ula;
      // Latch the pre-update PC so a same-cycle PC write does not move the fetch.
      if (w_inicia_busca) begin
        r_mem_end <= PC;
      end
      if (w_captura) begin
        r_ir <= mem.mem_dado;
      end
    end
  end

  assign mem.mem_req   = (r_estado == BUSCA);
  assign mem.mem_end   = r_mem_end;
  assign busca_ativa   = (r_estado == BUSCA);
  assign instr_valida  = (r_estado == CARREGADO);

  assign IR     = r_ir;
  assign opcode = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign rd     = r_ir[RD_MSB:RD_LSB];
  assign rs     = r_ir[RS_MSB:RS_LSB];
  assign rt     = r_ir[RT_MSB:RT_LSB];
  assign alvo   = r_ir[ALVO_MSB:ALVO_LSB];

endmodule

`default_nettype wire

// File: tb/tb_unidade_busca.sv
// +----------------------------------------------------------------------+
// | tb_unidade_busca: directed self-checking bench for unidade_busca.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_unidade_busca;

  logic        clk = 1'b0;
  logic        reset;
  logic        EscIR, EscCP, EscCondCP, zero;
  logic [1:0]  FonteCP;
  logic [7:0]  resultado_ula;
  logic [7:0]  PC;
  logic [15:0] IR;
  logic [3:0]  opcode, rd, rs, rt;
  logic [7:0]  alvo;
  logic        instr_valida, busca_ativa;

  int n_chk  = 0;
  int n_fail = 0;

  unidade_busca_if #(.LARGURA_INSTR(16), .LARGURA_END(8)) mem_bus ();

  unidade_busca #(
    .LARGURA_INSTR (16),
    .LARGURA_END   (8),
    .END_INICIAL   (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .EscIR         (EscIR),
    .EscCP         (EscCP),
    .EscCondCP     (EscCondCP),
    .FonteCP       (FonteCP),
    .zero          (zero),
    .resultado_ula (resultado_ula),
    .mem           (mem_bus),
    .PC            (PC),
    .IR            (IR),
    .opcode        (opcode),
    .rd            (rd),
    .rs            (rs),
    .rt            (rt),
    .alvo          (alvo),
    .instr_valida  (instr_valida),
    .busca_ativa   (busca_ativa)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       esc_cp;
    logic       esc_cond_cp;
    logic       zero;
    logic [1:0] fonte;
    logic [7:0] ula;
    logic [7:0] exp_pc;
  } vetor_t;

  localparam int N_VET = 12;
  vetor_t tabela [N_VET];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_chk++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
    end
  endtask

  initial begin
    tabela[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h05, 8'h05};
    tabela[1]  = '{1'b1, 1'b0, 1'b0, 2'b10, 8'h33, 8'hA7};
    tabela[2]  = '{1'b1, 1'b0, 1'b0, 2'b11, 8'h44, 8'hA7};
    tabela[3]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'hFF, 8'hA7};
    tabela[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF};
    tabela[5]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00};
    tabela[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h20, 8'h00};
    tabela[7]  = '{1'b0, 1'b1, 1'b0, 2'b01, 8'h20, 8'h00};
    tabela[8]  = '{1'b0, 1'b1, 1'b1, 2'b01, 8'h20, 8'h20};
    tabela[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h3C, 8'h20};
    tabela[10] = '{1'b1, 1'b0, 1'b0, 2'b01, 8'h77, 8'h3C};
    tabela[11] = '{1'b0, 1'b1, 1'b1, 2'b00, 8'h08, 8'h08};

    reset = 1'b1; EscIR = 1'b0; EscCP = 1'b0; EscCondCP = 1'b0; zero = 1'b0;
    FonteCP = 2'b11; resultado_ula = 8'h00;
    mem_bus.mem_pronto = 1'b1; mem_bus.mem_dado = 16'hFFFF;

    // Reset with a stray mem_pronto
    tick(); tick();
    reset = 1'b0; mem_bus.mem_pronto = 1'b0;
    chk("rst_pc", PC, 8'h00);
    chk("rst_ir", IR, 16'h0000);
    chk("rst_mem_req", mem_bus.mem_req, 1'b0);
    chk("rst_mem_end", mem_bus.mem_end, 8'h00);
    chk("rst_valida", instr_valida, 1'b0);
    chk("rst_ativa", busca_ativa, 1'b0);

    // Basic fetch, three wait cycles
    EscIR = 1'b1; tick(); EscIR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busca_req", mem_bus.mem_req, 1'b1);
      chk("busca_end", mem_bus.mem_end, 8'h00);
      chk("busca_valida", instr_valida, 1'b0);
      if (i == 3) begin
        mem_bus.mem_pronto = 1'b1; mem_bus.mem_dado = 16'h1234;
      end
      tick();
    end
    mem_bus.mem_pronto = 1'b0;
    chk("busca_ir", IR, 16'h1234);
    chk("busca_opcode", opcode, 4'h1);
    chk("busca_rd", rd, 4'h2);
    chk("busca_rs", rs, 4'h3);
    chk("busca_rt", rt, 4'h4);
    chk("busca_fim_valida", instr_valida, 1'b1);
    chk("busca_fim_req", mem_bus.mem_req, 1'b0);
    chk("busca_fim_ativa", busca_ativa, 1'b0);

    // Minimum-latency fetch of a jump word
    EscIR = 1'b1; tick(); EscIR = 1'b0;
    mem_bus.mem_pronto = 1'b1; mem_bus.mem_dado = 16'hB0A7;
    chk("min_req", mem_bus.mem_req, 1'b1);
    tick();
    mem_bus.mem_pronto = 1'b0;
    chk("min_valida", instr_valida, 1'b1);
    chk("min_ir", IR, 16'hB0A7);
    chk("min_alvo", alvo, 8'hA7);

    // PC source table
    for (int v = 0; v < N_VET; v++) begin
      EscCP = tabela[v].esc_cp; EscCondCP = tabela[v].esc_cond_cp;
      zero = tabela[v].zero; FonteCP = tabela[v].fonte;
      resultado_ula = tabela[v].ula;
      tick();
      chk($sformatf("tabela_pc[%0d]", v), PC, tabela[v].exp_pc);
      chk($sformatf("tabela_req[%0d]", v), mem_bus.mem_req, 1'b0);
    end
    EscCP = 1'b0; EscCondCP = 1'b0; zero = 1'b0; FonteCP = 2'b11;

    // EscIR together with a PC write, then a second EscIR during BUSCA
    EscIR = 1'b1; EscCP = 1'b1; FonteCP = 2'b00; resultado_ula = 8'h09;
    tick();
    chk("simul_end", mem_bus.mem_end, 8'h08);
    chk("simul_pc", PC, 8'h09);
    chk("simul_req", mem_bus.mem_req, 1'b1);
    resultado_ula = 8'h10;
    tick();
    EscIR = 1'b0; EscCP = 1'b0; FonteCP = 2'b11;
    chk("simul_end_estavel", mem_bus.mem_end, 8'h08);
    chk("simul_pc2", PC, 8'h10);
    chk("simul_ativa", busca_ativa, 1'b1);
    mem_bus.mem_pronto = 1'b1; mem_bus.mem_dado = 16'h5A5A;
    tick();
    mem_bus.mem_pronto = 1'b0;
    chk("simul_ir", IR, 16'h5A5A);
    chk("simul_valida", instr_valida, 1'b1);
    tick(); tick();
    chk("simul_sem_segunda", mem_bus.mem_req, 1'b0);
    chk("simul_valida2", instr_valida, 1'b1);
    mem_bus.mem_pronto = 1'b1; mem_bus.mem_dado = 16'hFFFF;
    tick();
    mem_bus.mem_pronto = 1'b0;
    chk("pronto_fora_busca", IR, 16'h5A5A);

    // Reset in the middle of a fetch
    EscIR = 1'b1; tick(); EscIR = 1'b0;
    chk("meio_ativa", busca_ativa, 1'b1);
    chk("meio_end", mem_bus.mem_end, 8'h10);
    reset = 1'b1; tick(); reset = 1'b0;
    mem_bus.mem_pronto = 1'b1; mem_bus.mem_dado = 16'hFFFF;
    tick();
    chk("meio_ir", IR, 16'h0000);
    chk("meio_req", mem_bus.mem_req, 1'b0);
    chk("meio_valida", instr_valida, 1'b0);
    chk("meio_ativa_fim", busca_ativa, 1'b0);
    chk("meio_pc", PC, 8'h00);
    tick();
    mem_bus.mem_pronto = 1'b0;
    chk("meio_ir2", IR, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
Instruction-fetch stage directly upstream of the multi-cycle control unit.
- Holds the PC and the instruction register (IR).
- Fetches instructions from instruction memory through a req/ready handshake.
- Slices IR into opcode and register fields for the controller and register bank.
- Applies PC updates commanded by the controller (EscCP, EscCondCP, FonteCP).

Parameters:
LARGURA_INSTR, 16, instruction width; field layout below assumes 16
LARGURA_END, 8, PC / instruction-memory address width
END_INICIAL, 0, PC value loaded on reset

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
EscIR  in  1  controller request: fetch instruction at current PC into IR
EscCP  in  1  unconditional PC write
EscCondCP  in  1  conditional PC write, qualified by zero
FonteCP  in  2  PC source select
zero  in  1  ALU zero flag
resultado_ula  in  LARGURA_END  ALU result (PC+1 or branch target)
mem_req  out  1  fetch request to instruction memory
mem_end  out  LARGURA_END  fetch address
mem_dado  in  LARGURA_INSTR  instruction word from memory
mem_pronto  in  1  memory data valid, sampled only while mem_req=1
PC  out  LARGURA_END  program counter
IR  out  LARGURA_INSTR  instruction register
opcode  out  4  IR[15:12]
rd  out  4  IR[11:8]
rs  out  4  IR[7:4]
rt  out  4  IR[3:0]
alvo  out  8  IR[7:0], jump target / immediate field
instr_valida  out  1  IR holds a completed, current fetch
busca_ativa  out  1  fetch outstanding; controller must stall

Behaviour:
- Reset (synchronous, active-high), all outputs:
  - PC=END_INICIAL, IR=0, ula_reg=0, state OCIOSO
  - mem_req=0, mem_end=0, instr_valida=0, busca_ativa=0
  - Reset mid-fetch abandons the fetch; a later mem_pronto is ignored.
- ula_reg: internal register; captures resultado_ula every cycle (branch target held across states).
- PC write:
  - Condition: EscCP | (EscCondCP & zero), evaluated each cycle.
  - Source: FonteCP 00 resultado_ula; 01 ula_reg; 10 IR[7:0] (zero-extended to LARGURA_END); 11 no write.
  - No write condition: PC holds.
  - Wrap-around is modular in LARGURA_END (255+1 -> 0); the block performs no saturation.
- States and transitions: OCIOSO, BUSCA, CARREGADO.
  - OCIOSO/CARREGADO, EscIR=1 at edge t -> BUSCA.
    - Cycle t+1: mem_req=1, mem_end=PC sampled at t (pre-update value if a PC write occurs in the same cycle), instr_valida=0, busca_ativa=1.
  - BUSCA: mem_end held stable even if PC changes.
    - EscIR ignored (no queueing).
    - mem_pronto=1 at edge k: IR<=mem_dado, -> CARREGADO.
    - Cycle k+1: instr_valida=1, mem_req=0, busca_ativa=0.
    - Minimum latency EscIR -> instr_valida: 2 cycles (mem_pronto in first BUSCA cycle).
    - Unbounded wait, no timeout.
  - CARREGADO: IR and fields stable until the next fetch completes.
- mem_pronto outside BUSCA: ignored.
- opcode/rd/rs/rt/alvo: combinational slices of IR.
- Simultaneous EscIR and PC write in one cycle: both take effect; fetch uses old PC, PC updates.

Decomposition:
- Shared package (controle_pkg), used by this block and the control unit:
  - FonteCP codes: FCP_ULA=2'b00, FCP_ALVO_ULA=2'b01, FCP_JUMP=2'b10, FCP_NENHUM=2'b11.
  - Fetch-state encoding.
  - Opcode field positions and widths.
- One sub-module, registrador_pc:
  - Contains the PC register, write-enable logic, and FonteCP mux.
- Fetch FSM and IR stay in unidade_busca.

Test Plan:
- Reset: assert reset 2 cycles while mem_pronto=1 -> PC=0, IR=0, mem_req=0, instr_valida=0.
- Basic fetch:
  - Stimulus: PC=0, EscIR pulse; memory returns 16'h1234 after 3 wait cycles.
  - Response: mem_req=1 with mem_end=0 for 4 cycles; then IR=16'h1234, opcode=1, rd=2, rs=3, rt=4, instr_valida=1.
- PC sources:
  - EscCP=1, FonteCP=00, resultado_ula=8'h05 -> PC=5.
  - FonteCP=10, IR=16'hB0A7 -> PC=8'hA7.
  - FonteCP=11 -> PC unchanged.
  - PC=8'hFF, resultado_ula=0 -> PC=0.
- Conditional branch:
  - ula_reg=8'h20 (resultado_ula=8'h20 one cycle earlier); EscCondCP=1, FonteCP=01, zero=0 -> PC unchanged.
  - Repeat with zero=1 -> PC=8'h20.
- Simultaneous events:
  - EscIR and EscCP (resultado_ula=9) together at PC=8 -> mem_end=8, PC=9.
  - Second EscIR during BUSCA -> ignored, only one fetch completes.
- Reset mid-fetch:
  - Reset during BUSCA, then mem_pronto=1 with 16'hFFFF -> IR stays 0, state OCIOSO, mem_req=0.
